// File: rtl/fp16_pkg.sv
// fp16_pkg
// Shared format constants for the binary16 -> int16 conversion path and
// the converter's state encoding.
//   FP16_*     : binary16 field widths, bias and all-ones exponent
//   INT16_*    : saturation limits of the signed 16-bit result
//   EXP_*      : biased-exponent class boundaries used at accept time
//   state_t    : converter FSM states
package fp16_pkg;

  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MAN_W   = 10;
  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;

  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;

  // Biased exponent that marks Inf/NaN.
  localparam logic [4:0] EXP_ALL_ONES = 5'(FP16_EXP_MAX);
  // Unbiased exponent >= 15 no longer fits a signed 16-bit integer.
  localparam logic [4:0] EXP_SAT      = 5'(FP16_BIAS + 15);
  // Unbiased exponent <= -2 means |x| < 0.5, which always rounds to 0.
  localparam logic [4:0] EXP_TINY     = 5'(FP16_BIAS - 2);
  // Unbiased exponent equal to the mantissa width: the hidden-bit
  // significand already sits at the integer binary point.
  localparam logic [4:0] EXP_ALIGN    = 5'(FP16_BIAS + FP16_MAN_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/complimenter_2.sv
// complimenter_2
// Conditional two's-complement negation.
//   i_en   : 1 = output -i_data, 0 = pass i_data through
//   i_data : operand
//   o_data : result (same width, wraps modulo 2^WIDTH)
module complimenter_2 #(
  parameter int WIDTH = 16
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign o_data = i_en ? (~i_data + ONE) : i_data;

endmodule

// File: rtl/fp16_to_int_converter.sv
// fp16_to_int_converter
// Converts an IEEE-754 binary16 operand to a signed 16-bit integer with
// round-to-nearest-even. Alignment uses a 1-bit-per-cycle shifter; specials,
// out-of-range and tiny values are resolved at accept time.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   x                    : fp16 operand {sign, exp[4:0], man[9:0]}
//   out_valid / out_ready: result handshake (result held until taken)
//   r                    : signed integer result
//   negative, cout,
//   overflow, zero       : ALU-style flags registered with r
module fp16_to_int_converter
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        negative,
  output logic        cout,
  output logic        overflow,
  output logic        zero
);

  state_t r_state;
  state_t w_state_next;

  // Operand fields
  logic                  w_sign;
  logic [FP16_EXP_W-1:0] w_exp;
  logic [FP16_MAN_W-1:0] w_man;

  assign w_sign = x[FP16_MAN_W + FP16_EXP_W];
  assign w_exp  = x[FP16_MAN_W +: FP16_EXP_W];
  assign w_man  = x[FP16_MAN_W-1:0];

  logic w_accept;
  logic w_out_fire;

  assign w_accept   = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Accept-time classification: anything that does not need the shifter
  // gets its final result here and goes straight to OUT.
  logic        w_is_direct;
  logic [15:0] w_direct_r;
  logic        w_direct_ovf;

  always_comb begin
    w_is_direct  = 1'b0;
    w_direct_r   = '0;
    w_direct_ovf = 1'b0;
    if (w_exp == EXP_ALL_ONES) begin
      // Only +Inf saturates high; -Inf and every NaN map to the minimum.
      w_is_direct  = 1'b1;
      w_direct_ovf = 1'b1;
      w_direct_r   = (w_sign || (w_man != '0)) ? INT16_MIN : INT16_MAX;
    end else if (w_exp >= EXP_SAT) begin
      w_is_direct = 1'b1;
      if (w_sign && (w_exp == EXP_SAT) && (w_man == '0)) begin
        // -2^15 is representable exactly.
        w_direct_r   = INT16_MIN;
        w_direct_ovf = 1'b0;
      end else begin
        w_direct_r   = w_sign ? INT16_MIN : INT16_MAX;
        w_direct_ovf = 1'b1;
      end
    end else if (w_exp <= EXP_TINY) begin
      w_is_direct  = 1'b1;
      w_direct_r   = '0;
      w_direct_ovf = 1'b0;
    end
  end

  // Shift direction and distance relative to the integer binary point.
  logic       w_left;
  logic [3:0] w_cnt;

  assign w_left = (w_exp >= EXP_ALIGN);
  assign w_cnt  = w_left ? 4'(w_exp - EXP_ALIGN) : 4'(EXP_ALIGN - w_exp);

  // Datapath registers
  logic        r_sign;
  logic [15:0] r_acc;
  logic        r_guard;
  logic        r_sticky;
  logic        r_left;
  logic [3:0]  r_cnt;
  logic [15:0] r_r;
  logic        r_overflow;
  logic        r_negative;
  logic        r_zero;

  // Round to nearest, ties to even. Largest magnitude reaching here is
  // 0x7FF0, so the increment never carries out of 16 bits.
  logic        w_inc;
  logic [15:0] w_mag;
  logic [15:0] w_signed;

  assign w_inc = r_guard & (r_sticky | r_acc[0]);
  assign w_mag = r_acc + {15'd0, w_inc};

  complimenter_2 #(
    .WIDTH(16)
  ) u_neg (
    .i_en  (r_sign),
    .i_data(w_mag),
    .o_data(w_signed)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_direct) begin
            w_state_next = OUT;
          end else if (w_cnt == 4'd0) begin
            w_state_next = ROUND;
          end else begin
            w_state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = ROUND;
        end
      end
      ROUND: begin
        w_state_next = OUT;
      end
      OUT: begin
        if (w_out_fire) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_acc      <= '0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_left     <= 1'b0;
      r_cnt      <= '0;
      r_r        <= '0;
      r_overflow <= 1'b0;
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign   <= w_sign;
            r_acc    <= {5'b0, 1'b1, w_man};
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_left   <= w_left;
            r_cnt    <= w_cnt;
            if (w_is_direct) begin
              r_r        <= w_direct_r;
              r_overflow <= w_direct_ovf;
              r_negative <= w_direct_r[15];
              r_zero     <= (w_direct_r == '0);
            end
          end
        end
        SHIFT: begin
          if (r_left) begin
            r_acc <= {r_acc[14:0], 1'b0};
          end else begin
            // Bits shifted out feed the guard; anything below the guard
            // collapses into sticky.
            r_sticky <= r_sticky | r_guard;
            r_guard  <= r_acc[0];
            r_acc    <= {1'b0, r_acc[15:1]};
          end
          r_cnt <= r_cnt - 4'd1;
        end
        ROUND: begin
          r_r        <= w_signed;
          r_overflow <= 1'b0;
          r_negative <= w_signed[15];
          r_zero     <= (w_signed == '0);
        end
        default: begin
          // OUT holds the result stable.
        end
      endcase
    end
  end

  assign r        = r_r;
  assign negative = r_negative;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign cout     = 1'b0;

endmodule

// File: tb/tb_fp16_to_int_converter.sv
module tb_fp16_to_int_converter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        negative;
  logic        cout;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  fp16_to_int_converter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r        (r),
    .negative (negative),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] r;
    logic        ovf;
    logic        neg;
    logic        zr;
    int          lat;
  } vec_t;

  localparam vec_t BASIC [2] = '{
    '{16'h4248, 16'h0003, 1'b0, 1'b0, 1'b0, 11},
    '{16'h6400, 16'h0400, 1'b0, 1'b0, 1'b0, 2}
  };

  localparam vec_t TIES [6] = '{
    '{16'h4100, 16'h0002, 1'b0, 1'b0, 1'b0, 11},
    '{16'h4300, 16'h0004, 1'b0, 1'b0, 1'b0, 11},
    '{16'h3800, 16'h0000, 1'b0, 1'b0, 1'b1, 13},
    '{16'hBE00, 16'hFFFE, 1'b0, 1'b1, 1'b0, 12},
    '{16'h3C01, 16'h0001, 1'b0, 1'b0, 1'b0, 12},
    '{16'hB800, 16'h0000, 1'b0, 1'b0, 1'b1, 13}
  };

  localparam vec_t RANGE [4] = '{
    '{16'h77FF, 16'h7FF0, 1'b0, 1'b0, 1'b0, 6},
    '{16'hF800, 16'h8000, 1'b0, 1'b1, 1'b0, 1},
    '{16'h7800, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1},
    '{16'h7BFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1}
  };

  localparam vec_t SPECIALS [5] = '{
    '{16'h7C00, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1},
    '{16'hFC00, 16'h8000, 1'b1, 1'b1, 1'b0, 1},
    '{16'h7E00, 16'h8000, 1'b1, 1'b1, 1'b0, 1},
    '{16'h03FF, 16'h0000, 1'b0, 1'b0, 1'b1, 1},
    '{16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1}
  };

  // Drives one operand and collects the result. Called and returns at
  // posedge+1. lat counts edges from the accept edge (inclusive) to the
  // edge that raises out_valid; 999 marks an expired wait.
  task automatic run_conv(input logic [15:0] xin, output logic [15:0] r_o,
                          output logic [3:0] f_o, output int lat);
    int w;
    r_o = '0;
    f_o = '0;
    lat = 999;
    x = xin;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      lat = 999;
      return;
    end
    r_o = r;
    f_o = {overflow, negative, zero, cout};
    $display("tx x=%h r=%h ovf=%b neg=%b zero=%b cout=%b lat=%0d",
             xin, r_o, f_o[3], f_o[2], f_o[1], f_o[0], lat);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    checks++;
    if ({r, overflow, negative, zero, cout} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got r=%h ovf=%b neg=%b zero=%b cout=%b exp all 0",
               r, overflow, negative, zero, cout);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] got_r;
    logic [3:0]  got_f;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_conv(BASIC[i].x, got_r, got_f, lat);
      checks++;
      if (got_r !== BASIC[i].r) begin
        errors++;
        $display("FAIL basic_r x=%h got %h exp %h", BASIC[i].x, got_r, BASIC[i].r);
      end
      checks++;
      if (got_f !== {BASIC[i].ovf, BASIC[i].neg, BASIC[i].zr, 1'b0}) begin
        errors++;
        $display("FAIL basic_flags x=%h got %b exp %b", BASIC[i].x, got_f,
                 {BASIC[i].ovf, BASIC[i].neg, BASIC[i].zr, 1'b0});
      end
      checks++;
      if (lat !== BASIC[i].lat) begin
        errors++;
        $display("FAIL basic_latency x=%h got %0d exp %0d", BASIC[i].x, lat, BASIC[i].lat);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] got_r;
    logic [3:0]  got_f;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_conv(TIES[i].x, got_r, got_f, lat);
      checks++;
      if (got_r !== TIES[i].r) begin
        errors++;
        $display("FAIL round_r x=%h got %h exp %h", TIES[i].x, got_r, TIES[i].r);
      end
      checks++;
      if (got_f !== {TIES[i].ovf, TIES[i].neg, TIES[i].zr, 1'b0}) begin
        errors++;
        $display("FAIL round_flags x=%h got %b exp %b", TIES[i].x, got_f,
                 {TIES[i].ovf, TIES[i].neg, TIES[i].zr, 1'b0});
      end
      checks++;
      if (lat !== TIES[i].lat) begin
        errors++;
        $display("FAIL round_latency x=%h got %0d exp %0d", TIES[i].x, lat, TIES[i].lat);
      end
    end
  endtask

  task automatic test_range_limits();
    logic [15:0] got_r;
    logic [3:0]  got_f;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_conv(RANGE[i].x, got_r, got_f, lat);
      checks++;
      if (got_r !== RANGE[i].r) begin
        errors++;
        $display("FAIL range_r x=%h got %h exp %h", RANGE[i].x, got_r, RANGE[i].r);
      end
      checks++;
      if (got_f !== {RANGE[i].ovf, RANGE[i].neg, RANGE[i].zr, 1'b0}) begin
        errors++;
        $display("FAIL range_flags x=%h got %b exp %b", RANGE[i].x, got_f,
                 {RANGE[i].ovf, RANGE[i].neg, RANGE[i].zr, 1'b0});
      end
      checks++;
      if (lat !== RANGE[i].lat) begin
        errors++;
        $display("FAIL range_latency x=%h got %0d exp %0d", RANGE[i].x, lat, RANGE[i].lat);
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] got_r;
    logic [3:0]  got_f;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_conv(SPECIALS[i].x, got_r, got_f, lat);
      checks++;
      if (got_r !== SPECIALS[i].r) begin
        errors++;
        $display("FAIL special_r x=%h got %h exp %h", SPECIALS[i].x, got_r, SPECIALS[i].r);
      end
      checks++;
      if (got_f !== {SPECIALS[i].ovf, SPECIALS[i].neg, SPECIALS[i].zr, 1'b0}) begin
        errors++;
        $display("FAIL special_flags x=%h got %b exp %b", SPECIALS[i].x, got_f,
                 {SPECIALS[i].ovf, SPECIALS[i].neg, SPECIALS[i].zr, 1'b0});
      end
      checks++;
      if (lat !== SPECIALS[i].lat) begin
        errors++;
        $display("FAIL special_latency x=%h got %0d exp %0d", SPECIALS[i].x, lat, SPECIALS[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    x = 16'h4100;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    // A second operand is presented immediately and must be ignored.
    x = 16'h4300;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_first_valid got out_valid=%b exp 1 within 40 cycles", out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({out_valid, in_ready, r, overflow, negative, zero} !== {1'b1, 1'b0, 16'h0002, 3'b000}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got out_valid=%b in_ready=%b r=%h ovf=%b neg=%b zero=%b exp 1 0 0002 0 0 0",
                 c, out_valid, in_ready, r, overflow, negative, zero);
      end
      @(posedge clk); #1;
    end
    $display("tx x=4100 r=%h held under backpressure", r);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_after_handshake got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept got in_ready=%b exp 0", in_ready);
    end
    in_valid = 1'b0;
    w = 1;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (r !== 16'h0004 || w !== 11) begin
      errors++;
      $display("FAIL bp_second_result got r=%h lat=%0d exp 0004 lat=11", r, w);
    end
    $display("tx x=4300 r=%h lat=%0d after backpressure", r, w);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    logic [15:0] got_r;
    logic [3:0]  got_f;
    int          lat;
    int          w;
    bit          saw_valid;
    x = 16'h4248;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, r, overflow, negative, zero, cout} !== {1'b0, 1'b1, 20'h0}) begin
      errors++;
      $display("FAIL midreset_state got out_valid=%b in_ready=%b r=%h ovf=%b neg=%b zero=%b cout=%b exp 0 1 0000 0 0 0 0",
               out_valid, in_ready, r, overflow, negative, zero, cout);
    end
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_emit got out_valid seen=%b exp 0", saw_valid);
    end
    run_conv(16'h3C00, got_r, got_f, lat);
    checks++;
    if (got_r !== 16'h0001 || got_f !== 4'b0000 || lat !== 12) begin
      errors++;
      $display("FAIL midreset_next got r=%h flags=%b lat=%0d exp 0001 0000 12", got_r, got_f, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range_limits();
    test_specials();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp16_to_int_converter.md
Name: fp16_to_int_converter

Overview:
- Multi-cycle converter from IEEE-754 binary16 to signed 16-bit two's-complement integer, rounding to nearest, ties to even.
- Complements the int16-to-fp16 path in the integer ALU.
- Uses a valid/ready handshake on both sides.
- Produces ALU-standard flags (negative, cout, overflow, zero) and uses an iterative 1-bit-per-cycle alignment shifter to save area.

Parameters:
- None. The format is fixed to binary16 in and int16 out. Format constants live in the shared package.

Ports:
clk         in   1   clock, all state changes on rising edge
rst         in   1   synchronous, active-high reset
in_valid    in   1   x is valid
in_ready    out  1   converter can accept x (high only in IDLE)
x           in   16  fp16 operand {sign, exp[4:0], man[9:0]}
out_valid   out  1   r and flags valid
out_ready   in   1   consumer accepts r
r           out  16  signed integer result
negative    out  1   r[15]
cout        out  1   constant 0
overflow    out  1   input was Inf/NaN or out of int16 range (result saturated)
zero        out  1   r == 0

Behaviour:
- Reset (sync, active-high, priority over all else):
  - state=IDLE; in_ready=1; out_valid=0.
  - r=0; negative=0; overflow=0; zero=0; all internal registers cleared.
  - Reset mid-operation abandons the conversion. Nothing is emitted.
- States: IDLE, SHIFT, ROUND, OUT.
- Accept occurs on in_valid&in_ready (IDLE only). Latch sign s, e, m. Let E=e-15. Classify at accept:
  - e==31 (Inf/NaN): goto OUT with overflow=1. r=0x7FFF for +Inf; r=0x8000 for -Inf and any NaN.
  - e>=30 (E>=15): goto OUT with overflow=1 and r=0x7FFF if s=0, or r=0x8000 if s=1. Exception: s=1, e=30, m=0 gives exact -32768, so r=0x8000 with overflow=0.
  - e<=13 (E<=-2, includes zero and subnormals): goto OUT with r=0, overflow=0.
  - Otherwise: acc[15:0]={5'b0,1'b1,m}; guard=0; sticky=0; dir=left if E>=10; cnt=|E-10| (0..11). Goto SHIFT if cnt!=0, else ROUND.
- SHIFT (one bit per cycle):
  - Right: sticky|=guard; guard=acc[0]; acc>>=1.
  - Left: acc<<=1 (guard/sticky stay 0).
  - cnt-=1. When cnt reaches 0, goto ROUND.
- ROUND:
  - inc = guard & (sticky | acc[0]); mag = acc + inc. Width is 16 bits; mag<=32752 cannot overflow.
  - r = s ? -mag : mag. Goto OUT.
- OUT:
  - out_valid=1; r and flags held stable until out_ready. On out_valid&out_ready, goto IDLE.
  - in_ready=0 in every non-IDLE state; in_valid is ignored there.
- Flags are registered together with r:
  - negative=r[15]; zero=(r==0); cout=0.
  - -0.0 and negative values that round to 0 give r=0, negative=0, zero=1.
- Latency, accept edge to out_valid rising:
  - Special and zero classes: 1 cycle.
  - Normal path: cnt+2 cycles. Min 2 (E=10), max 13 (E=-1).
- Throughput: one conversion in flight; next accept is possible the cycle after the OUT handshake.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16_EXP_W=5, FP16_MAN_W=10, FP16_BIAS=15, FP16_EXP_MAX=31.
  - INT16_MAX=16'h7FFF, INT16_MIN=16'h8000.
  - State enum {IDLE, SHIFT, ROUND, OUT}.
- Negation in ROUND reuses the existing complimenter_2 #(.WIDTH(16)) with enable=s. No other sub-module.

Test Plan:
- x=0x4248 (3.140625) -> r=0x0003, overflow=0, zero=0. out_valid 11 cycles after accept.
- Ties and signs:
  - 0x4100 (2.5) -> 0x0002.
  - 0x4300 (3.5) -> 0x0004.
  - 0x3800 (0.5) -> 0x0000, zero=1 (13 cycles).
  - 0xBE00 (-1.5) -> 0xFFFE, negative=1.
  - 0x3C01 -> 0x0001.
- Range limits:
  - 0x77FF -> 0x7FF0 (6 cycles).
  - 0xF800 -> 0x8000, overflow=0.
  - 0x7800 -> 0x7FFF, overflow=1.
  - 0x7BFF -> 0x7FFF, overflow=1.
  - All three special cases respond in 1 cycle.
- Specials and tiny values:
  - 0x7C00 -> 0x7FFF, overflow=1.
  - 0xFC00 -> 0x8000, overflow=1.
  - 0x7E00 -> 0x8000, overflow=1.
  - 0x03FF and 0x8000 -> 0x0000, zero=1, negative=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a new x. r and flags stay stable, in_ready=0, second operand not accepted until the cycle after the out_ready handshake.
- Assert rst during SHIFT of 0x4248 -> next cycle out_valid=0, in_ready=1, r=0, all flags 0. A following 0x3C00 -> r=0x0001.
